// File: rtl/sbox_lanes.sv
// Two-stage, LANES-wide AES S-box substitution with valid/ready back-pressure.
// Define SBOX_INV_EN to add the per-beat in_inv port and the inverse S-box.
module sbox_lanes #(
  parameter int unsigned LANES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES*8-1:0] in_data,
`ifdef SBOX_INV_EN
  input  logic               in_inv,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*8-1:0] out_data,
  output logic               busy
);

  logic               s1_valid;
  logic [LANES*8-1:0] s1_data;
  logic [LANES*8-1:0] lookup;
  logic               s1_adv;
  logic               s2_adv;
`ifdef SBOX_INV_EN
  logic               s1_inv;
`endif

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = '0;
    t = a;
    for (int unsigned k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // Multiplicative inverse in GF(2^8) as x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] r;
    sq = x;
    r  = 8'h01;
    for (int unsigned k = 1; k < 8; k++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    logic [7:0] s;
    s = gf_inv(x);
    return s ^ {s[6:0], s[7]} ^ {s[5:0], s[7:6]} ^ {s[4:0], s[7:5]} ^ {s[3:0], s[7:4]} ^ 8'h63;
  endfunction

`ifdef SBOX_INV_EN
  function automatic logic [7:0] sbox_inv(input logic [7:0] x);
    logic [7:0] y;
    y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return gf_inv(y);
  endfunction
`endif

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;
  assign busy     = s1_valid || out_valid;

  always_comb begin
    lookup = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
`ifdef SBOX_INV_EN
      lookup[8*i +: 8] = s1_inv ? sbox_inv(s1_data[8*i +: 8]) : sbox_fwd(s1_data[8*i +: 8]);
`else
      lookup[8*i +: 8] = sbox_fwd(s1_data[8*i +: 8]);
`endif
    end
  end

  // Data registers only load alongside a valid beat, so out_data holds its last value across bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_data   <= '0;
`ifdef SBOX_INV_EN
      s1_inv    <= 1'b0;
`endif
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_data <= in_data;
`ifdef SBOX_INV_EN
          s1_inv  <= in_inv;
`endif
        end
      end
      if (s2_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) out_data <= lookup;
      end
    end
  end

endmodule
